// File: rtl/riscv_pkg.sv
// Shared definitions for the writeback / register file slice:
// result-select encoding and the architectural register indices used here.
package riscv_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  localparam int REG_ZERO = 0;
  localparam int REG_A0   = 10;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register storage: two asynchronous read ports, one write
// port, x0 hardwired to zero, plus a dedicated tap of x10 for display.
module regfile_2r1w
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [0:NREGS-1];

  // Storage update: async clear of every entry, writes to x0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != ADDR_WIDTH'(REG_ZERO))) begin
      regs[waddr] <= wdata;
    end
  end

  // Combinational reads with x0 forced to zero regardless of array contents.
  always_comb begin
    rd1 = (ra1 == ADDR_WIDTH'(REG_ZERO)) ? '0 : regs[ra1];
    rd2 = (ra2 == ADDR_WIDTH'(REG_ZERO)) ? '0 : regs[ra2];
    a0  = regs[REG_A0];
  end

endmodule

// File: rtl/writeback_regfile.sv
// W-stage writeback: result mux, commit into the register file, decode read
// ports, retired-instruction counter and a0 display tap.
// Optional macro WB_REGFILE_BYPASS_EN: write-first read ports (same-cycle
// bypass of ResultW); default build is read-before-write.
module writeback_regfile
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWriteW,
  input  logic [1:0]            ResultSrcW,
  input  logic [DATA_WIDTH-1:0] ALUResultW,
  input  logic [DATA_WIDTH-1:0] ReadDataW,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic [DATA_WIDTH-1:0] PCPlus4W,
  input  logic                  ValidW,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic [DATA_WIDTH-1:0] ResultW,
  output logic [DATA_WIDTH-1:0] a0,
  output logic [CNT_WIDTH-1:0]  InstRet
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd1_arr;
  logic [DATA_WIDTH-1:0] rd2_arr;
  logic [DATA_WIDTH-1:0] a0_arr;

  // Writeback result select; the unused code 11 falls back to the ALU result.
  always_comb begin
    ResultW = ALUResultW;
    case (result_src_t'(ResultSrcW))
      RES_MEM: ResultW = ReadDataW;
      RES_PC4: ResultW = PCPlus4W;
      default: ResultW = ALUResultW;
    endcase
  end

  assign wr_en = RegWriteW && ValidW && (RdW != ADDR_WIDTH'(REG_ZERO));

  regfile_2r1w #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_regfile (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_en),
    .waddr(RdW),
    .wdata(ResultW),
    .ra1  (A1),
    .ra2  (A2),
    .rd1  (rd1_arr),
    .rd2  (rd2_arr),
    .a0   (a0_arr)
  );

`ifdef WB_REGFILE_BYPASS_EN
  // Write-first reads: a pending commit is visible in the same cycle; the
  // bypass is suppressed in reset so the ports still read zero.
  always_comb begin
    RD1 = rd1_arr;
    RD2 = rd2_arr;
    a0  = a0_arr;
    if (rst_n && wr_en && (RdW == A1)) RD1 = ResultW;
    if (rst_n && wr_en && (RdW == A2)) RD2 = ResultW;
    if (rst_n && wr_en && (RdW == ADDR_WIDTH'(REG_A0))) a0 = ResultW;
  end
`else
  // Read-before-write: ports show the stored value until the commit edge.
  always_comb begin
    RD1 = rd1_arr;
    RD2 = rd2_arr;
    a0  = a0_arr;
  end
`endif

  // Retire counter: every valid W-stage instruction counts, wrapping silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstRet <= '0;
    end else if (ValidW) begin
      InstRet <= InstRet + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile. A second instance with a
// 4-bit retire counter shares the stimulus to exercise counter wrap.
module tb_writeback_regfile;

  logic        clk;
  logic        rst_n;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [4:0]  RdW;
  logic [31:0] PCPlus4W;
  logic        ValidW;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] ResultW;
  logic [31:0] a0;
  logic [31:0] InstRet;

  logic [31:0] rd1_4;
  logic [31:0] rd2_4;
  logic [31:0] result_4;
  logic [31:0] a0_4;
  logic [3:0]  instret_4;

  int compared;
  int mismatched;

  writeback_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RegWriteW (RegWriteW),
    .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW),
    .ReadDataW (ReadDataW),
    .RdW       (RdW),
    .PCPlus4W  (PCPlus4W),
    .ValidW    (ValidW),
    .A1        (A1),
    .A2        (A2),
    .RD1       (RD1),
    .RD2       (RD2),
    .ResultW   (ResultW),
    .a0        (a0),
    .InstRet   (InstRet)
  );

  writeback_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .RegWriteW (RegWriteW),
    .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW),
    .ReadDataW (ReadDataW),
    .RdW       (RdW),
    .PCPlus4W  (PCPlus4W),
    .ValidW    (ValidW),
    .A1        (A1),
    .A2        (A2),
    .RD1       (rd1_4),
    .RD2       (rd2_4),
    .ResultW   (result_4),
    .a0        (a0_4),
    .InstRet   (instret_4)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic vld, input logic [1:0] src,
                               input logic [31:0] alu, input logic [31:0] mem,
                               input logic [31:0] pc4, input logic [4:0] rd);
    RegWriteW  = we;
    ValidW     = vld;
    ResultSrcW = src;
    ALUResultW = alu;
    ReadDataW  = mem;
    PCPlus4W   = pc4;
    RdW        = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0;
    A1 = 5'd5;
    A2 = 5'd31;
    idle();

    // Reset then read
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_rd1_in_reset", RD1, 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_rd1", RD1, 32'h0);
    checkOutput("rst_rd2", RD2, 32'h0);
    checkOutput("rst_instret", InstRet, 32'h0);
    checkOutput("rst_a0", a0, 32'h0);

    // Result mux and write to x3
    A1 = 5'd3;
    applyStimulus(1'b1, 1'b1, 2'b01, 32'h11, 32'h22, 32'h33, 5'd3);
    #1;
    checkOutput("mux_mem", ResultW, 32'h22);
    tick();
    checkOutput("wr_mem_x3", RD1, 32'h22);
    applyStimulus(1'b1, 1'b1, 2'b10, 32'h11, 32'h22, 32'h33, 5'd3);
    #1;
    checkOutput("mux_pc4", ResultW, 32'h33);
    tick();
    checkOutput("wr_pc4_x3", RD1, 32'h33);
    applyStimulus(1'b1, 1'b1, 2'b11, 32'h11, 32'h22, 32'h33, 5'd3);
    #1;
    checkOutput("mux_code11", ResultW, 32'h11);
    tick();
    checkOutput("wr_alu_x3", RD1, 32'h11);
    applyStimulus(1'b1, 1'b1, 2'b00, 32'h44, 32'h22, 32'h33, 5'd3);
    #1;
    checkOutput("mux_alu", ResultW, 32'h44);
    tick();
    checkOutput("instret_4", InstRet, 32'd4);

    // Write to x0 is dropped
    A1 = 5'd0;
    applyStimulus(1'b1, 1'b1, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 5'd0);
    tick();
    checkOutput("x0_read", RD1, 32'h0);

    // Bubble with RegWriteW=1 does not write or retire
    A2 = 5'd4;
    applyStimulus(1'b1, 1'b1, 2'b00, 32'h44, 32'h0, 32'h0, 5'd4);
    tick();
    checkOutput("x4_set", RD2, 32'h44);
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h99, 32'h0, 32'h0, 5'd4);
    tick();
    checkOutput("bubble_x4", RD2, 32'h44);
    checkOutput("bubble_instret", InstRet, 32'd6);

    // Same-cycle write/read of x10
    A1 = 5'd10;
    applyStimulus(1'b1, 1'b1, 2'b00, 32'h1234, 32'h0, 32'h0, 5'd10);
    tick();
    applyStimulus(1'b1, 1'b1, 2'b00, 32'hA5A5A5A5, 32'h0, 32'h0, 5'd10);
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    checkOutput("haz_rd1_pre", RD1, 32'hA5A5A5A5);
    checkOutput("haz_a0_pre", a0, 32'hA5A5A5A5);
`else
    checkOutput("haz_rd1_pre", RD1, 32'h1234);
    checkOutput("haz_a0_pre", a0, 32'h1234);
`endif
    tick();
    idle();
    #1;
    checkOutput("haz_rd1_post", RD1, 32'hA5A5A5A5);
    checkOutput("haz_a0_post", a0, 32'hA5A5A5A5);
    checkOutput("haz_instret", InstRet, 32'd8);

    // Counter: 7 valids with 2 bubbles, then wrap of the 4-bit counter
    rst_n = 1'b0;
    #1;
    checkOutput("cnt_reset", InstRet, 32'h0);
    checkOutput("cnt_reset_x10", RD1, 32'h0);
    rst_n = 1'b1;
    #1;
    begin
      logic [8:0] pattern;
      pattern = 9'b111_011_011;
      for (int i = 8; i >= 0; i--) begin
        applyStimulus(1'b0, pattern[i], 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
      end
    end
    idle();
    checkOutput("cnt_7", InstRet, 32'd7);
    checkOutput("cnt4_7", {28'h0, instret_4}, 32'd7);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
      tick();
    end
    idle();
    checkOutput("cnt_16", InstRet, 32'd16);
    checkOutput("cnt4_wrap", {28'h0, instret_4}, 32'd0);

    // Async reset during a write stream
    A1 = 5'd5;
    A2 = 5'd6;
    applyStimulus(1'b1, 1'b1, 2'b00, 32'h55, 32'h0, 32'h0, 5'd5);
    tick();
    checkOutput("stream_x5", RD1, 32'h55);
    applyStimulus(1'b1, 1'b1, 2'b00, 32'h66, 32'h0, 32'h0, 5'd6);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_x5", RD1, 32'h0);
    checkOutput("midrst_instret", InstRet, 32'h0);
    checkOutput("midrst_resultw", ResultW, 32'h66);
    tick();
    checkOutput("midrst_x6_blocked", RD2, 32'h0);
    checkOutput("midrst_instret_hold", InstRet, 32'h0);
    idle();
    rst_n = 1'b1;
    tick();
    checkOutput("postrst_x6", RD2, 32'h0);
    checkOutput("postrst_instret", InstRet, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
